// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: width defaults, grant indices
// and the read-return owner tag.
package mem_port_arbiter_pkg;
   localparam int REG_WIDTH_DEF  = 8;
   localparam int ADDR_WIDTH_DEF = 16;

   // Bit positions inside the one-hot grant vector
   localparam int G_LD  = 2;
   localparam int G_DMA = 1;
   localparam int G_CPU = 0;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LD   = 2'd1,
      OWN_DMA  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   function automatic owner_t gnt2owner(input logic [2:0] gnt);
      if (gnt[G_LD])  return OWN_LD;
      if (gnt[G_DMA]) return OWN_DMA;
      if (gnt[G_CPU]) return OWN_CPU;
      return OWN_NONE;
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-side and debug signals around the arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int REG_WIDTH  = REG_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();
   logic                  ld_req, dma_req, cpu_req;
   logic                  ld_we, dma_we, cpu_we;
   logic [ADDR_WIDTH-1:0] ld_addr, dma_addr, cpu_addr;
   logic [REG_WIDTH-1:0]  ld_wdata, dma_wdata, cpu_wdata;
   logic                  dma_lock, load_en;
   logic                  ld_gnt, dma_gnt, cpu_gnt;
   logic                  ld_rvalid, dma_rvalid, cpu_rvalid;
   logic [REG_WIDTH-1:0]  rdata;
   logic                  mem_en, mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [REG_WIDTH-1:0]  mem_wdata, mem_rdata;
   logic                  load_err;
   logic [3:0]            cpu_wait_cnt;

   modport slave (
      input  ld_req, dma_req, cpu_req, ld_we, dma_we, cpu_we,
             ld_addr, dma_addr, cpu_addr, ld_wdata, dma_wdata, cpu_wdata,
             dma_lock, load_en, mem_rdata,
      output ld_gnt, dma_gnt, cpu_gnt, ld_rvalid, dma_rvalid, cpu_rvalid,
             rdata, mem_en, mem_we, mem_addr, mem_wdata, load_err, cpu_wait_cnt
   );

   modport master (
      output ld_req, dma_req, cpu_req, ld_we, dma_we, cpu_we,
             ld_addr, dma_addr, cpu_addr, ld_wdata, dma_wdata, cpu_wdata,
             dma_lock, load_en, mem_rdata,
      input  ld_gnt, dma_gnt, cpu_gnt, ld_rvalid, dma_rvalid, cpu_rvalid,
             rdata, mem_en, mem_we, mem_addr, mem_wdata, load_err, cpu_wait_cnt
   );
endinterface

// File: rtl/mem_arb_prio.sv
// Combinational fixed-priority grant: loader, starved CPU, locked DMA, DMA, CPU.
module mem_arb_prio
   import mem_port_arbiter_pkg::*;
(
   input  logic       ld_req,
   input  logic       load_en,
   input  logic       dma_req,
   input  logic       cpu_req,
   input  logic       lock_q,
   input  logic       starved,
   output logic [2:0] gnt
);
   always_comb begin
      gnt = '0;
      if (ld_req && load_en)       gnt[G_LD]  = 1'b1;
      else if (starved && cpu_req) gnt[G_CPU] = 1'b1;
      else if (lock_q && dma_req)  gnt[G_DMA] = 1'b1;
      else if (dma_req)            gnt[G_DMA] = 1'b1;
      else if (cpu_req)            gnt[G_CPU] = 1'b1;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: zero-latency grant, DMA burst lock, CPU
// starvation guard and a one-cycle tagged read-return pipeline.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int REG_WIDTH  = REG_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int MAX_WAIT   = 4
) (
   input logic              clk,
   input logic              reset_n,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic                  lock_q, load_err_q, starved;
   logic [3:0]            wait_q;
   owner_t                tag_q;
   logic [REG_WIDTH-1:0]  rdata_q;
   logic [2:0]            prio_gnt, gnt;
   logic                  we_c;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic [REG_WIDTH-1:0]  wdata_c;

   assign starved = (wait_q == MAX_W);

   mem_arb_prio u_prio (
      .ld_req  (bus.ld_req),
      .load_en (bus.load_en),
      .dma_req (bus.dma_req),
      .cpu_req (bus.cpu_req),
      .lock_q  (lock_q),
      .starved (starved),
      .gnt     (prio_gnt)
   );

   // Grants are combinational, so hold them off while reset is asserted
   assign gnt = reset_n ? prio_gnt : 3'b000;

   always_comb begin
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
      if (gnt[G_LD]) begin
         we_c = bus.ld_we;  addr_c = bus.ld_addr;  wdata_c = bus.ld_wdata;
      end else if (gnt[G_DMA]) begin
         we_c = bus.dma_we; addr_c = bus.dma_addr; wdata_c = bus.dma_wdata;
      end else if (gnt[G_CPU]) begin
         we_c = bus.cpu_we; addr_c = bus.cpu_addr; wdata_c = bus.cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_q     <= 1'b0;
         wait_q     <= '0;
         load_err_q <= 1'b0;
         tag_q      <= OWN_NONE;
         rdata_q    <= '0;
      end else begin
         // A starvation grant leaves the lock alone so DMA resumes next cycle
         lock_q <= bus.dma_req && bus.dma_lock && (lock_q || gnt[G_DMA]);
         if (!bus.cpu_req || gnt[G_CPU]) wait_q <= '0;
         else if (!starved)              wait_q <= wait_q + 4'd1;
         if (bus.ld_req && !bus.load_en) load_err_q <= 1'b1;
         tag_q   <= (|gnt && !we_c) ? gnt2owner(gnt) : OWN_NONE;
         rdata_q <= bus.rdata;
      end
   end

   assign bus.ld_gnt       = gnt[G_LD];
   assign bus.dma_gnt      = gnt[G_DMA];
   assign bus.cpu_gnt      = gnt[G_CPU];
   assign bus.mem_en       = |gnt;
   assign bus.mem_we       = we_c;
   assign bus.mem_addr     = addr_c;
   assign bus.mem_wdata    = wdata_c;
   assign bus.ld_rvalid    = (tag_q == OWN_LD);
   assign bus.dma_rvalid   = (tag_q == OWN_DMA);
   assign bus.cpu_rvalid   = (tag_q == OWN_CPU);
   assign bus.rdata        = (tag_q != OWN_NONE) ? bus.mem_rdata : rdata_q;
   assign bus.load_err     = load_err_q;
   assign bus.cpu_wait_cnt = wait_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an abstract per-cycle reference
// model (priority rules, shadow memory, read queue) plus literal checks.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int RW = 8;
   localparam int AW = 16;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

   mem_port_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory array behind the port: registered read, one cycle latency
   logic [7:0] mem [0:65535];
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 3);
      mem[16] <= 8'h5A;
   end
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   // Reference model
   typedef struct { int cyc; int own; logic [7:0] data; } rd_t;
   rd_t        pq[$];
   logic [7:0] ref_mem [0:65535];
   int         cyc = 0;
   int         m_wait = 0;
   bit         m_err = 1'b0;
   logic [7:0] m_rdata = 8'h00;
   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 3);
      ref_mem[16] = 8'h5A;
   end

   always @(negedge clk) begin : cmp
      int         win, own;
      logic       ewe;
      logic [15:0] ea;
      logic [7:0] ed;
      cyc++;
      if (!reset_n) begin
         m_wait = 0; m_err = 1'b0; m_rdata = 8'h00; pq.delete();
         check("rst_gnt", 32'({bus.ld_gnt, bus.dma_gnt, bus.cpu_gnt}), 0);
         check("rst_mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
         check("rst_rvalid", 32'({bus.ld_rvalid, bus.dma_rvalid, bus.cpu_rvalid}), 0);
         check("rst_rdata", 32'(bus.rdata), 0);
         check("rst_err_cnt", 32'({bus.load_err, bus.cpu_wait_cnt}), 0);
      end else begin
         win = 0;
         if (bus.ld_req && bus.load_en)           win = 1;
         else if (bus.cpu_req && m_wait == MW)    win = 3;
         else if (bus.dma_req)                    win = 2;
         else if (bus.cpu_req)                    win = 3;
         ewe = 1'b0; ea = 16'h0; ed = 8'h0;
         case (win)
            1: begin ewe = bus.ld_we;  ea = bus.ld_addr;  ed = bus.ld_wdata;  end
            2: begin ewe = bus.dma_we; ea = bus.dma_addr; ed = bus.dma_wdata; end
            3: begin ewe = bus.cpu_we; ea = bus.cpu_addr; ed = bus.cpu_wdata; end
            default: ;
         endcase
         check("m_gnt", 32'({bus.ld_gnt, bus.dma_gnt, bus.cpu_gnt}),
               32'((win == 1) ? 3'b100 : (win == 2) ? 3'b010 : (win == 3) ? 3'b001 : 3'b000));
         check("m_mem_en", 32'(bus.mem_en), 32'(win != 0));
         check("m_mem_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'({ewe, ea, ed}));
         own = 0;
         if (pq.size() > 0 && pq[0].cyc == cyc - 1) begin
            own = pq[0].own; m_rdata = pq[0].data; void'(pq.pop_front());
         end
         check("m_rvalid", 32'({bus.ld_rvalid, bus.dma_rvalid, bus.cpu_rvalid}),
               32'({own == 1, own == 2, own == 3}));
         check("m_rdata", 32'(bus.rdata), 32'(m_rdata));
         check("m_load_err", 32'(bus.load_err), 32'(m_err));
         check("m_wait_cnt", 32'(bus.cpu_wait_cnt), 32'(m_wait));
         if (win != 0) begin
            if (ewe) ref_mem[ea] = ed;
            else     pq.push_back('{cyc, win, ref_mem[ea]});
         end
         if (bus.cpu_req && win != 3) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
         else                         m_wait = 0;
         if (bus.ld_req && !bus.load_en) m_err = 1'b1;
      end
   end

   int          exp_d[6] = '{1, 1, 1, 1, 0, 1};
   int          exp_c[6] = '{0, 1, 2, 3, 4, 0};
   logic [15:0] ra[4]    = '{16'h0000, 16'h003C, 16'h007F, 16'h00FF};
   int          nb, cpu_at, nc, nwin;
   logic        gd, gc, gl;

   task automatic idle();
      bus.ld_req = 0; bus.dma_req = 0; bus.cpu_req = 0;
      bus.ld_we = 0;  bus.dma_we = 0;  bus.cpu_we = 0;
      bus.ld_addr = 0; bus.dma_addr = 0; bus.cpu_addr = 0;
      bus.ld_wdata = 0; bus.dma_wdata = 0; bus.cpu_wdata = 0;
   endtask

   task automatic step_pos(); @(posedge clk); #1; endtask
   task automatic step_neg(); @(negedge clk); #1; endtask

   initial begin
      idle(); bus.load_en = 0; bus.dma_lock = 0;
      repeat (2) step_neg();
      check("reset_mem_en", 32'(bus.mem_en), 0);
      check("reset_wait_cnt", 32'(bus.cpu_wait_cnt), 0);
      step_pos(); reset_n = 1'b1;

      // Single CPU read of preloaded 0x5A
      step_pos(); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0010;
      step_neg(); check("t1_cpu_gnt", 32'(bus.cpu_gnt), 1);
      step_pos(); bus.cpu_req = 0;
      step_neg();
      check("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
      check("t1_rdata", 32'(bus.rdata), 32'h5A);
      check("t1_other_rvalid", 32'({bus.ld_rvalid, bus.dma_rvalid}), 0);

      // DMA vs CPU without lock: CPU forced in on the fifth cycle
      step_pos();
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h0300; bus.dma_wdata = 8'h11;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0310; bus.cpu_wdata = 8'h22;
      for (int k = 0; k < 6; k++) begin
         step_neg();
         check("t2_dma_gnt", 32'(bus.dma_gnt), exp_d[k]);
         check("t2_cpu_gnt", 32'(bus.cpu_gnt), 32'(exp_d[k] == 0));
         check("t2_wait_cnt", 32'(bus.cpu_wait_cnt), exp_c[k]);
         step_pos();
         if (k == 4) bus.cpu_req = 0;
      end
      bus.dma_req = 0;

      // Locked DMA burst with CPU starvation break-in
      bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 1;
      bus.dma_addr = 16'h0200; bus.dma_wdata = 8'hA0;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0400; bus.cpu_wdata = 8'h77;
      nb = 0; cpu_at = -1; nc = 0;
      while (nb < 8 && nc < 20) begin
         step_neg(); gd = bus.dma_gnt; gc = bus.cpu_gnt;
         if (gc) cpu_at = nc;
         step_pos();
         if (gc) bus.cpu_req = 0;
         if (gd) begin
            nb++;
            bus.dma_addr = 16'h0200 + 16'(nb); bus.dma_wdata = 8'hA0 + 8'(nb);
            if (nb == 8) begin bus.dma_req = 0; bus.dma_lock = 0; end
         end
         nc++;
      end
      check("t3_cpu_slot", 32'(cpu_at), 4);
      check("t3_cycles", 32'(nc), 9);
      step_pos();
      for (int j = 0; j < 8; j++) check("t3_burst_byte", 32'(mem[16'h0200 + 16'(j)]), 32'(8'hA0 + 8'(j)));
      check("t3_cpu_byte", 32'(mem[16'h0400]), 32'h77);

      // Loader image 0x00..0xFF while DMA and CPU also request
      bus.load_en = 1; bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 0; bus.ld_wdata = 0;
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0500;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0600;
      nwin = 0;
      for (int i = 0; i < 256; i++) begin
         step_neg(); gl = bus.ld_gnt;
         if (gl && !bus.dma_gnt && !bus.cpu_gnt) nwin++;
         step_pos();
         if (gl) begin bus.ld_addr = 16'(i + 1); bus.ld_wdata = 8'(i + 1); end
         if (i == 255) begin bus.ld_req = 0; bus.dma_req = 0; bus.cpu_req = 0; end
      end
      check("t4_loader_wins", 32'(nwin), 256);

      // Back-to-back CPU readback of the loaded image
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = ra[0];
      for (int k = 0; k < 5; k++) begin
         step_neg();
         if (k > 0) begin
            check("t4_rb_rvalid", 32'(bus.cpu_rvalid), 1);
            check("t4_rb_rdata", 32'(bus.rdata), 32'(ra[k-1][7:0]));
         end
         if (k < 4) check("t4_rb_gnt", 32'(bus.cpu_gnt), 1);
         step_pos();
         if (k < 3) bus.cpu_addr = ra[k+1];
         if (k == 3) bus.cpu_req = 0;
      end

      // Two owners back to back: returns in issue order, then rdata holds
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0005;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0006;
      step_neg(); check("t5_dma_first", 32'(bus.dma_gnt), 1);
      step_pos(); bus.dma_req = 0;
      step_neg();
      check("t5_cpu_second", 32'(bus.cpu_gnt), 1);
      check("t5_dma_ret", 32'({bus.dma_rvalid, bus.rdata}), 32'({1'b1, 8'h05}));
      step_pos(); bus.cpu_req = 0;
      step_neg();
      check("t5_cpu_ret", 32'({bus.dma_rvalid, bus.cpu_rvalid, bus.rdata}), 32'({2'b01, 8'h06}));
      step_neg();
      check("t5_rdata_hold", 32'({bus.cpu_rvalid, bus.rdata}), 32'({1'b0, 8'h06}));

      // Loader with load_en low: no grant, sticky error
      step_pos();
      check("t6_err_before", 32'(bus.load_err), 0);
      bus.load_en = 0; bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 16'h0700;
      step_neg(); check("t6_no_gnt", 32'({bus.ld_gnt, bus.mem_en}), 0);
      step_neg(); check("t6_err_set", 32'(bus.load_err), 1);
      step_pos(); bus.ld_req = 0;
      repeat (3) step_neg();
      check("t6_err_sticky", 32'(bus.load_err), 1);

      // Reset between a DMA read grant and its return
      step_pos(); bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0042;
      step_neg(); check("t7_dma_gnt", 32'(bus.dma_gnt), 1);
      reset_n = 1'b0; bus.dma_req = 0;
      step_neg();
      check("t7_no_rvalid", 32'(bus.dma_rvalid), 0);
      check("t7_outputs", 32'({bus.load_err, bus.mem_en, bus.rdata, bus.cpu_wait_cnt}), 0);
      reset_n = 1'b1;
      step_neg();
      check("t7_after", 32'({bus.dma_rvalid, bus.rdata}), 0);

      repeat (2) step_pos();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
